// File: rtl/alu_control.sv
// ALU control decoder: maps ALUOp and R-type funct to a 4-bit ALU operation, registered with a valid strobe.
// Optional macro ALU_CTRL_NOR_EN adds decoding of funct 100111 (nor) to operation 1100.
module alu_control (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] operation,
    output logic       out_valid,
    output logic       illegal
);

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
`ifdef ALU_CTRL_NOR_EN
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
`endif

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_CTRL_NOR_EN
    localparam logic [3:0] OP_NOR = 4'b1100;
`endif
    // Never a real ALU op, so downstream can spot bad decodes from operation alone
    localparam logic [3:0] OP_BAD = 4'b1111;

    logic [3:0] decodeOp;
    logic       decodeIllegal;

    always_comb begin
        decodeOp      = OP_BAD;
        decodeIllegal = 1'b1;
        case (aluop)
            ALUOP_MEM: begin
                decodeOp      = OP_ADD;
                decodeIllegal = 1'b0;
            end
            ALUOP_BEQ: begin
                decodeOp      = OP_SUB;
                decodeIllegal = 1'b0;
            end
            ALUOP_RTYPE: begin
                decodeIllegal = 1'b0;
                case (funct)
                    FUNCT_ADD: decodeOp = OP_ADD;
                    FUNCT_SUB: decodeOp = OP_SUB;
                    FUNCT_AND: decodeOp = OP_AND;
                    FUNCT_OR:  decodeOp = OP_OR;
                    FUNCT_SLT: decodeOp = OP_SLT;
`ifdef ALU_CTRL_NOR_EN
                    FUNCT_NOR: decodeOp = OP_NOR;
`endif
                    default: begin
                        decodeOp      = OP_BAD;
                        decodeIllegal = 1'b1;
                    end
                endcase
            end
            default: begin
                decodeOp      = OP_BAD;
                decodeIllegal = 1'b1;
            end
        endcase
    end

    // Result registers hold across idle cycles; only the strobe drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operation <= 4'b0000;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                operation <= decodeOp;
                illegal   <= decodeIllegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed vector table plus async reset sequences.
// Expected nor decode follows ALU_CTRL_NOR_EN as seen by this compile.
module tb_alu_control;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [3:0] operation;
    logic       out_valid;
    logic       illegal;

    int checks;
    int failures;

`ifdef ALU_CTRL_NOR_EN
    localparam logic [3:0] NOR_OP  = 4'b1100;
    localparam logic       NOR_ILL = 1'b0;
`else
    localparam logic [3:0] NOR_OP  = 4'b1111;
    localparam logic       NOR_ILL = 1'b1;
`endif

    typedef struct {
        string      name;
        logic       v;
        logic [1:0] op2;
        logic [5:0] fn;
        logic [3:0] expOp;
        logic       expValid;
        logic       expIllegal;
    } vec_t;

    vec_t vecs[15];

    alu_control dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .aluop     (aluop),
        .funct     (funct),
        .operation (operation),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] expOp,
                               input logic expValid, input logic expIllegal);
        checks++;
        if (operation !== expOp) begin
            failures++;
            $display("[TB] FAIL %s operation: got %b expected %b", name, operation, expOp);
        end
        checks++;
        if (out_valid !== expValid) begin
            failures++;
            $display("[TB] FAIL %s out_valid: got %b expected %b", name, out_valid, expValid);
        end
        checks++;
        if (illegal !== expIllegal) begin
            failures++;
            $display("[TB] FAIL %s illegal: got %b expected %b", name, illegal, expIllegal);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the next rising edge
    task automatic applyStimulus(input logic v, input logic [1:0] a, input logic [5:0] f);
        @(negedge clk);
        in_valid = v;
        aluop    = a;
        funct    = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        aluop    = 2'b00;
        funct    = 6'b000000;

        vecs[0]  = '{"mem_funct_ignored", 1'b1, 2'b00, 6'b111111, 4'b0010, 1'b1, 1'b0};
        vecs[1]  = '{"beq_funct_ignored", 1'b1, 2'b01, 6'b111111, 4'b0110, 1'b1, 1'b0};
        vecs[2]  = '{"r_add",             1'b1, 2'b10, 6'b100000, 4'b0010, 1'b1, 1'b0};
        vecs[3]  = '{"r_sub",             1'b1, 2'b10, 6'b100010, 4'b0110, 1'b1, 1'b0};
        vecs[4]  = '{"r_and",             1'b1, 2'b10, 6'b100100, 4'b0000, 1'b1, 1'b0};
        vecs[5]  = '{"r_or",              1'b1, 2'b10, 6'b100101, 4'b0001, 1'b1, 1'b0};
        vecs[6]  = '{"r_slt",             1'b1, 2'b10, 6'b101010, 4'b0111, 1'b1, 1'b0};
        vecs[7]  = '{"r_funct_zero",      1'b1, 2'b10, 6'b000000, 4'b1111, 1'b1, 1'b1};
        vecs[8]  = '{"aluop_reserved",    1'b1, 2'b11, 6'b100000, 4'b1111, 1'b1, 1'b1};
        vecs[9]  = '{"mem_again",         1'b1, 2'b00, 6'b000000, 4'b0010, 1'b1, 1'b0};
        vecs[10] = '{"hold_legal_a",      1'b0, 2'b10, 6'b000000, 4'b0010, 1'b0, 1'b0};
        vecs[11] = '{"hold_legal_b",      1'b0, 2'b11, 6'b101010, 4'b0010, 1'b0, 1'b0};
        vecs[12] = '{"r_nor",             1'b1, 2'b10, 6'b100111, NOR_OP,  1'b1, NOR_ILL};
        vecs[13] = '{"r_funct_101111",    1'b1, 2'b10, 6'b101111, 4'b1111, 1'b1, 1'b1};
        vecs[14] = '{"hold_illegal",      1'b0, 2'b01, 6'b100000, 4'b1111, 1'b0, 1'b1};

        #3;
        checkOutput("reset_state", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].v, vecs[i].op2, vecs[i].fn);
            checkOutput(vecs[i].name, vecs[i].expOp, vecs[i].expValid, vecs[i].expIllegal);
        end

        // Async reset mid-cycle while a legal result is held with out_valid high
        applyStimulus(1'b1, 2'b10, 6'b101010);
        checkOutput("pre_reset_slt", 4'b0111, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_legal", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-cycle while an illegal result is held
        applyStimulus(1'b1, 2'b11, 6'b000000);
        checkOutput("pre_reset_illegal", 4'b1111, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_illegal", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b1, 2'b01, 6'b000000);
        checkOutput("post_reset_beq", 4'b0110, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 6'b000000);
        checkOutput("post_reset_idle", 4'b0110, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
